// File: rtl/secmon_pkg.sv
// rtl/secmon_pkg.sv - shared responses, FSM states and access decode for the security monitor register file
package secmon_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        WR_IDLE = 1'b0,
        WR_RESP = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

    // Decode order: unmapped index, then non-secure access to a secure
    // register, then (writes only) the seal protecting secure registers and LOCK.
    function automatic logic [1:0] access_check(
        input int unsigned idx,
        input logic [2:0]  prot,
        input logic        sealed,
        input logic        is_write,
        input int unsigned num_regs,
        input logic [63:0] secure_mask
    );
        logic [1:0] resp;
        logic       is_secure;
        logic       is_lock;
        logic       unused_prot;
        unused_prot = prot[0] ^ prot[2];
        is_secure   = |(secure_mask & (64'd1 << idx));
        is_lock     = (idx == num_regs - 1);
        if (idx >= num_regs) begin
            resp = RESP_DECERR;
        end else if (is_secure && prot[1]) begin
            resp = RESP_SLVERR;
        end else if (is_write && sealed && (is_secure || is_lock)) begin
            resp = RESP_SLVERR;
        end else begin
            resp = RESP_OKAY;
        end
        return resp;
    endfunction

endpackage

// File: rtl/secmon_viol_counter.sv
// rtl/secmon_viol_counter.sv - saturating violation counter with a one-cycle interrupt pulse
module secmon_viol_counter
    import secmon_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_viol_i,
    input  logic        rd_viol_i,
    output logic [15:0] count_o,
    output logic        irq_o
);

    logic [15:0] count_q, count_d;
    logic        irq_q, irq_d;
    logic [16:0] sum;

    // Add both strobes at once so a simultaneous read+write violation counts twice but pulses once.
    always_comb begin
        sum     = {1'b0, count_q} + {16'd0, wr_viol_i} + {16'd0, rd_viol_i};
        count_d = sum[16] ? 16'hFFFF : sum[15:0];
        irq_d   = wr_viol_i | rd_viol_i;
    end

    // Count and pulse register, landing on the same edge that raises BVALID/RVALID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 16'd0;
            irq_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            irq_q   <= irq_d;
        end
    end

    assign count_o = count_q;
    assign irq_o   = irq_q;

endmodule

// File: rtl/secmon_axil_regfile.sv
// rtl/secmon_axil_regfile.sv - AXI4-Lite register file with secure access control, seal and violation reporting
module secmon_axil_regfile
    import secmon_pkg::*;
#(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 6,
    parameter int                  NUM_REGS           = 16,
    parameter logic [NUM_REGS-1:0] SECURE_MASK        = 16'h00FF
) (
    input  logic                               S_AXI_ACLK,
    input  logic                               S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic                               sealed,
    output logic [15:0]                        viol_count,
    output logic                               viol_irq
);

    localparam int          DW         = C_S_AXI_DATA_WIDTH;
    localparam int          AW         = C_S_AXI_ADDR_WIDTH;
    localparam int          SW         = DW / 8;
    localparam int          ADDR_LSB   = $clog2(SW);
    localparam int          IDX_W      = AW - ADDR_LSB;
    localparam int          LOCK_IDX   = NUM_REGS - 1;
    localparam logic [63:0] SEC_MASK64 = 64'(SECURE_MASK);

    wr_state_t        wr_state_q, wr_state_d;
    rd_state_t        rd_state_q, rd_state_d;

    logic             aw_full_q, aw_full_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    logic             aw_nsec_q, aw_nsec_d;
    logic             w_full_q, w_full_d;
    logic [DW-1:0]    w_data_q, w_data_d;
    logic [SW-1:0]    w_strb_q, w_strb_d;
    logic [1:0]       bresp_q, bresp_d;

    logic [DW-1:0]    rdata_q, rdata_d;
    logic [1:0]       rresp_q, rresp_d;

    logic [DW-1:0]    regs_q [NUM_REGS];
    logic [DW-1:0]    regs_d [NUM_REGS];

    logic             aw_hs, w_hs, ar_hs;
    logic             wr_commit;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_nsec;
    logic [DW-1:0]    wr_data;
    logic [SW-1:0]    wr_strb;
    logic [1:0]       wr_resp;
    logic             wr_viol;
    logic [IDX_W-1:0] rd_idx;
    logic [1:0]       rd_resp;
    logic [DW-1:0]    rd_word;
    logic             rd_viol;
    logic             seal_bit;
    logic             unused_bits;

    assign unused_bits = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0],
                           S_AXI_AWPROT[2], S_AXI_AWPROT[0]};

    assign S_AXI_AWREADY = (wr_state_q == WR_IDLE) && !aw_full_q;
    assign S_AXI_WREADY  = (wr_state_q == WR_IDLE) && !w_full_q;
    assign S_AXI_ARREADY = (rd_state_q == RD_IDLE);
    assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = (rd_state_q == RD_DATA);
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    assign seal_bit = regs_q[LOCK_IDX][0];
    assign sealed   = seal_bit;

    // Buffered halves take precedence; otherwise the half arriving this cycle is used directly.
    assign wr_idx  = aw_full_q ? aw_idx_q  : S_AXI_AWADDR[AW-1:ADDR_LSB];
    assign wr_nsec = aw_full_q ? aw_nsec_q : S_AXI_AWPROT[1];
    assign wr_data = w_full_q  ? w_data_q  : S_AXI_WDATA;
    assign wr_strb = w_full_q  ? w_strb_q  : S_AXI_WSTRB;

    assign wr_commit = (wr_state_q == WR_IDLE) && (aw_full_q || aw_hs) && (w_full_q || w_hs);
    assign wr_resp   = access_check(32'(wr_idx), {1'b0, wr_nsec, 1'b0}, seal_bit, 1'b1,
                                    NUM_REGS, SEC_MASK64);

    assign rd_idx  = S_AXI_ARADDR[AW-1:ADDR_LSB];
    assign rd_resp = access_check(32'(rd_idx), S_AXI_ARPROT, seal_bit, 1'b0,
                                  NUM_REGS, SEC_MASK64);

    // Write FSM: collect AW and W independently, commit when both are present, hold B until accepted.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        aw_nsec_d  = aw_nsec_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bresp_d    = bresp_q;
        wr_viol    = 1'b0;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_full_d = 1'b1;
                    aw_idx_d  = S_AXI_AWADDR[AW-1:ADDR_LSB];
                    aw_nsec_d = S_AXI_AWPROT[1];
                end
                if (w_hs) begin
                    w_full_d = 1'b1;
                    w_data_d = S_AXI_WDATA;
                    w_strb_d = S_AXI_WSTRB;
                end
                if (wr_commit) begin
                    wr_state_d = WR_RESP;
                    bresp_d    = wr_resp;
                    wr_viol    = (wr_resp != RESP_OKAY);
                end
            end
            WR_RESP: begin
                if (S_AXI_BREADY) begin
                    wr_state_d = WR_IDLE;
                    aw_full_d  = 1'b0;
                    w_full_d   = 1'b0;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Register update: strobed byte lanes on an OKAY commit; LOCK keeps only its sticky bit 0.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_commit && (wr_resp == RESP_OKAY)) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    for (int b = 0; b < SW; b++) begin
                        if (wr_strb[b]) begin
                            regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
        regs_d[LOCK_IDX] = {{(DW-1){1'b0}}, regs_d[LOCK_IDX][0] | seal_bit};
    end

    // Read FSM: capture data and response on AR, using pre-write contents, hold until RREADY.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_viol    = 1'b0;
        rd_word    = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_word = regs_q[i];
            end
        end
        case (rd_state_q)
            RD_IDLE: begin
                if (ar_hs) begin
                    rd_state_d = RD_DATA;
                    rresp_d    = rd_resp;
                    rdata_d    = (rd_resp == RESP_OKAY) ? rd_word : '0;
                    rd_viol    = (rd_resp != RESP_OKAY);
                end
            end
            RD_DATA: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Write channel state and buffers; reset discards any half-collected write.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state_q <= WR_IDLE;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            aw_nsec_q  <= 1'b0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            aw_nsec_q  <= aw_nsec_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bresp_q    <= bresp_d;
        end
    end

    // Read channel state and registered response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state_q <= RD_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Register storage.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[g*DW +: DW] = regs_q[g];
    end

    secmon_viol_counter u_viol_counter (
        .clk       (S_AXI_ACLK),
        .rst_n     (S_AXI_ARESETN),
        .wr_viol_i (wr_viol),
        .rd_viol_i (rd_viol),
        .count_o   (viol_count),
        .irq_o     (viol_irq)
    );

endmodule

// File: tb/tb_secmon_axil_regfile.sv
// tb/tb_secmon_axil_regfile.sv - directed self-checking bench for secmon_axil_regfile
module tb_secmon_axil_regfile;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   irq_cnt_a = 0;
    int   irq_cnt_b = 0;

    logic [5:0]   a_awaddr, a_araddr;
    logic [2:0]   a_awprot, a_arprot;
    logic         a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
    logic [31:0]  a_wdata, a_rdata;
    logic [3:0]   a_wstrb;
    logic [1:0]   a_bresp, a_rresp;
    logic         a_arvalid, a_arready, a_rvalid, a_rready;
    logic [511:0] a_reg_q;
    logic         a_sealed, a_viol_irq;
    logic [15:0]  a_viol_count;

    logic [5:0]   b_awaddr, b_araddr;
    logic [2:0]   b_awprot, b_arprot;
    logic         b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
    logic [31:0]  b_wdata, b_rdata;
    logic [3:0]   b_wstrb;
    logic [1:0]   b_bresp, b_rresp;
    logic         b_arvalid, b_arready, b_rvalid, b_rready;
    logic [383:0] b_reg_q;
    logic         b_sealed, b_viol_irq;
    logic [15:0]  b_viol_count;

    secmon_axil_regfile dut_a (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(a_awaddr), .S_AXI_AWPROT(a_awprot), .S_AXI_AWVALID(a_awvalid), .S_AXI_AWREADY(a_awready),
        .S_AXI_WDATA(a_wdata), .S_AXI_WSTRB(a_wstrb), .S_AXI_WVALID(a_wvalid), .S_AXI_WREADY(a_wready),
        .S_AXI_BRESP(a_bresp), .S_AXI_BVALID(a_bvalid), .S_AXI_BREADY(a_bready),
        .S_AXI_ARADDR(a_araddr), .S_AXI_ARPROT(a_arprot), .S_AXI_ARVALID(a_arvalid), .S_AXI_ARREADY(a_arready),
        .S_AXI_RDATA(a_rdata), .S_AXI_RRESP(a_rresp), .S_AXI_RVALID(a_rvalid), .S_AXI_RREADY(a_rready),
        .reg_q(a_reg_q), .sealed(a_sealed), .viol_count(a_viol_count), .viol_irq(a_viol_irq)
    );

    secmon_axil_regfile #(.NUM_REGS(12), .SECURE_MASK(12'h0FF)) dut_b (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(b_awaddr), .S_AXI_AWPROT(b_awprot), .S_AXI_AWVALID(b_awvalid), .S_AXI_AWREADY(b_awready),
        .S_AXI_WDATA(b_wdata), .S_AXI_WSTRB(b_wstrb), .S_AXI_WVALID(b_wvalid), .S_AXI_WREADY(b_wready),
        .S_AXI_BRESP(b_bresp), .S_AXI_BVALID(b_bvalid), .S_AXI_BREADY(b_bready),
        .S_AXI_ARADDR(b_araddr), .S_AXI_ARPROT(b_arprot), .S_AXI_ARVALID(b_arvalid), .S_AXI_ARREADY(b_arready),
        .S_AXI_RDATA(b_rdata), .S_AXI_RRESP(b_rresp), .S_AXI_RVALID(b_rvalid), .S_AXI_RREADY(b_rready),
        .reg_q(b_reg_q), .sealed(b_sealed), .viol_count(b_viol_count), .viol_irq(b_viol_irq)
    );

    // Interrupt pulse tally, sampled away from the active edge.
    always @(negedge clk) begin
        if (a_viol_irq === 1'b1) irq_cnt_a <= irq_cnt_a + 1;
        if (b_viol_irq === 1'b1) irq_cnt_b <= irq_cnt_b + 1;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [5:0] addr, input logic [2:0] prot, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp, output logic irq);
        int   n;
        logic aw_pend, w_pend, aw_fire, w_fire;
        a_awaddr = addr; a_awprot = prot; a_wdata = data; a_wstrb = strb;
        a_awvalid = 1'b1; a_wvalid = 1'b1;
        aw_pend = 1'b1; w_pend = 1'b1; n = 0;
        while ((aw_pend || w_pend) && n < 20) begin
            aw_fire = a_awvalid && a_awready;
            w_fire  = a_wvalid && a_wready;
            @(negedge clk);
            n++;
            if (aw_fire) begin a_awvalid = 1'b0; aw_pend = 1'b0; end
            if (w_fire)  begin a_wvalid  = 1'b0; w_pend  = 1'b0; end
        end
        a_awvalid = 1'b0; a_wvalid = 1'b0;
        n = 0;
        while (!a_bvalid && n < 20) begin @(negedge clk); n++; end
        chk("wr_bvalid", a_bvalid, 1);
        resp = a_bresp;
        irq  = a_viol_irq;
        a_bready = 1'b1;
        @(negedge clk);
        a_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, input logic [2:0] prot,
                            output logic [31:0] data, output logic [1:0] resp, output logic irq);
        int n;
        a_araddr = addr; a_arprot = prot; a_arvalid = 1'b1;
        n = 0;
        while (!a_arready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        a_arvalid = 1'b0;
        n = 0;
        while (!a_rvalid && n < 20) begin @(negedge clk); n++; end
        chk("rd_rvalid", a_rvalid, 1);
        data = a_rdata;
        resp = a_rresp;
        irq  = a_viol_irq;
        a_rready = 1'b1;
        @(negedge clk);
        a_rready = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic        irq;
        logic [31:0] rd;

        rst_n = 1'b0;
        a_awaddr = '0; a_awprot = '0; a_awvalid = 1'b0; a_wdata = '0; a_wstrb = '0; a_wvalid = 1'b0;
        a_bready = 1'b0; a_araddr = '0; a_arprot = '0; a_arvalid = 1'b0; a_rready = 1'b0;
        b_awaddr = '0; b_awprot = '0; b_awvalid = 1'b0; b_wdata = '0; b_wstrb = '0; b_wvalid = 1'b0;
        b_bready = 1'b0; b_araddr = '0; b_arprot = '0; b_arvalid = 1'b0; b_rready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_awready", a_awready, 1);
        chk("rst_wready", a_wready, 1);
        chk("rst_arready", a_arready, 1);
        chk("rst_bvalid", a_bvalid, 0);
        chk("rst_rvalid", a_rvalid, 0);
        chk("rst_bresp", a_bresp, 0);
        chk("rst_rresp", a_rresp, 0);
        chk("rst_rdata", a_rdata, 0);
        chk("rst_reg_q", a_reg_q, 0);
        chk("rst_sealed", a_sealed, 0);
        chk("rst_viol_count", a_viol_count, 0);
        chk("rst_viol_irq", a_viol_irq, 0);

        for (int i = 0; i < 4; i++) begin
            axi_write(6'(i * 4), 3'b000, 32'(i + 1), 4'hF, resp, irq);
            chk("basic_bresp", resp, OKAY);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(6'(i * 4), 3'b000, rd, resp, irq);
            chk("basic_rdata", rd, 32'(i + 1));
            chk("basic_rresp", resp, OKAY);
        end
        chk("basic_viol_count", a_viol_count, 0);

        axi_write(6'd16, 3'b000, 32'h11223344, 4'hF, resp, irq);
        chk("skew_init_bresp", resp, OKAY);
        a_wdata = 32'hAABBCCDD; a_wstrb = 4'b0101; a_wvalid = 1'b1;
        @(negedge clk);
        a_wvalid = 1'b0;
        chk("skew_wready_held", a_wready, 0);
        chk("skew_awready_open", a_awready, 1);
        @(negedge clk);
        @(negedge clk);
        chk("skew_no_early_bvalid", a_bvalid, 0);
        a_awaddr = 6'd16; a_awprot = 3'b000; a_awvalid = 1'b1;
        @(negedge clk);
        a_awvalid = 1'b0;
        chk("skew_bvalid_latency", a_bvalid, 1);
        chk("skew_bresp", a_bresp, OKAY);
        chk("skew_reg4", a_reg_q[4*32 +: 32], 32'h11BB33DD);
        a_bready = 1'b1;
        @(negedge clk);
        a_bready = 1'b0;
        chk("skew_wready_free", a_wready, 1);
        axi_read(6'd16, 3'b000, rd, resp, irq);
        chk("skew_rdata", rd, 32'h11BB33DD);

        axi_write(6'd8, 3'b010, 32'h0000FFFF, 4'hF, resp, irq);
        chk("nsec_wr_bresp", resp, SLVERR);
        chk("nsec_wr_irq", irq, 1);
        chk("nsec_wr_viol_count", a_viol_count, 1);
        chk("nsec_wr_reg2", a_reg_q[2*32 +: 32], 32'd3);
        axi_write(6'd36, 3'b010, 32'h00000099, 4'hF, resp, irq);
        chk("nsec_wr9_bresp", resp, OKAY);
        chk("nsec_wr9_reg9", a_reg_q[9*32 +: 32], 32'h99);
        chk("nsec_wr9_viol_count", a_viol_count, 1);

        axi_read(6'd8, 3'b010, rd, resp, irq);
        chk("nsec_rd_rresp", resp, SLVERR);
        chk("nsec_rd_rdata", rd, 0);
        chk("nsec_rd_viol_count", a_viol_count, 2);

        a_awaddr = 6'd8; a_awprot = 3'b010; a_wdata = 32'h5A5A5A5A; a_wstrb = 4'hF;
        a_awvalid = 1'b1; a_wvalid = 1'b1;
        a_araddr = 6'd4; a_arprot = 3'b010; a_arvalid = 1'b1;
        @(negedge clk);
        a_awvalid = 1'b0; a_wvalid = 1'b0; a_arvalid = 1'b0;
        chk("dual_bresp", a_bresp, SLVERR);
        chk("dual_rresp", a_rresp, SLVERR);
        chk("dual_irq_high", a_viol_irq, 1);
        chk("dual_viol_count", a_viol_count, 4);
        a_bready = 1'b1; a_rready = 1'b1;
        @(negedge clk);
        a_bready = 1'b0; a_rready = 1'b0;
        chk("dual_irq_low", a_viol_irq, 0);
        chk("irq_pulses_a", irq_cnt_a, 3);

        a_awaddr = 6'd12; a_awprot = 3'b000; a_wdata = 32'h00000033; a_wstrb = 4'hF;
        a_awvalid = 1'b1; a_wvalid = 1'b1;
        a_araddr = 6'd12; a_arprot = 3'b000; a_arvalid = 1'b1;
        @(negedge clk);
        a_awvalid = 1'b0; a_wvalid = 1'b0; a_arvalid = 1'b0;
        chk("coll_rdata_old", a_rdata, 32'd4);
        chk("coll_rresp", a_rresp, OKAY);
        chk("coll_reg3_new", a_reg_q[3*32 +: 32], 32'h33);
        a_bready = 1'b1; a_rready = 1'b1;
        @(negedge clk);
        a_bready = 1'b0; a_rready = 1'b0;

        axi_write(6'd60, 3'b000, 32'h00000001, 4'hF, resp, irq);
        chk("seal_set_bresp", resp, OKAY);
        chk("seal_sealed", a_sealed, 1);
        axi_write(6'd0, 3'b000, 32'h0000DEAD, 4'hF, resp, irq);
        chk("seal_wr0_bresp", resp, SLVERR);
        chk("seal_wr0_reg0", a_reg_q[0 +: 32], 32'd1);
        axi_write(6'd60, 3'b000, 32'h00000000, 4'hF, resp, irq);
        chk("seal_clr_bresp", resp, SLVERR);
        chk("seal_still_sealed", a_sealed, 1);
        chk("seal_lock_reg", a_reg_q[15*32 +: 32], 32'd1);
        axi_read(6'd0, 3'b000, rd, resp, irq);
        chk("seal_rd0_rresp", resp, OKAY);
        chk("seal_rd0_rdata", rd, 32'd1);
        chk("seal_viol_count", a_viol_count, 6);

        b_araddr = 6'd52; b_arprot = 3'b000; b_arvalid = 1'b1;
        @(negedge clk);
        b_arvalid = 1'b0;
        chk("unmap_rvalid", b_rvalid, 1);
        chk("unmap_rresp", b_rresp, DECERR);
        chk("unmap_rdata", b_rdata, 0);
        chk("unmap_irq_high", b_viol_irq, 1);
        chk("unmap_viol_count", b_viol_count, 1);
        b_rready = 1'b1;
        @(negedge clk);
        b_rready = 1'b0;
        chk("unmap_irq_low", b_viol_irq, 0);
        @(negedge clk);
        chk("unmap_irq_pulses", irq_cnt_b, 1);

        a_awaddr = 6'd4; a_awprot = 3'b000; a_awvalid = 1'b1;
        @(negedge clk);
        a_awvalid = 1'b0;
        chk("rstmid_aw_buffered", a_awready, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_awready", a_awready, 1);
        chk("rstmid_bvalid", a_bvalid, 0);
        chk("rstmid_reg_q", a_reg_q, 0);
        chk("rstmid_sealed", a_sealed, 0);
        chk("rstmid_viol_count", a_viol_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        a_wdata = 32'hCAFEF00D; a_wstrb = 4'hF; a_wvalid = 1'b1;
        @(negedge clk);
        a_wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rstmid_no_bvalid", a_bvalid, 0);
            @(negedge clk);
        end
        chk("rstmid_reg_q_after", a_reg_q, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
